// File: rtl/mux29_rr_sched.sv
// Round-robin grant scheduler for a shared 29:1 one-bit mux tree.
// Holds each grant for a bounded tenure and drives the matching mux select code.
module mux29_rr_sched #(
  parameter int unsigned HOLD_MAX = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [28:0] req,
  input  logic        done,
  output logic [28:0] grant,
  output logic        grant_valid,
  output logic [4:0]  grant_idx,
  output logic [7:0]  sel,
  output logic        timeout
);

  localparam int unsigned N     = 29;
  localparam int unsigned IDX_W = 5;
  localparam int unsigned SEL_W = 8;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state;
  logic [IDX_W-1:0]   ptr;
  logic [CNT_W-1:0]   cnt;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W:0]     cand;
  logic               release_c;

  // Mux tree select code for each input index; unused bits driven 0.
  function automatic logic [SEL_W-1:0] sel_of(input logic [IDX_W-1:0] i);
    logic [SEL_W-1:0] s;
    case (i)
      5'd0:    s = 8'b00000000;
      5'd1:    s = 8'b00000001;
      5'd2:    s = 8'b00000010;
      5'd3:    s = 8'b00000100;
      5'd4:    s = 8'b00000101;
      5'd5:    s = 8'b00000110;
      5'd6:    s = 8'b00010000;
      5'd7:    s = 8'b00010001;
      5'd8:    s = 8'b00010010;
      5'd9:    s = 8'b00010100;
      5'd10:   s = 8'b00010101;
      5'd11:   s = 8'b00010110;
      5'd12:   s = 8'b01000000;
      5'd13:   s = 8'b01000001;
      5'd14:   s = 8'b01000010;
      5'd15:   s = 8'b01000100;
      5'd16:   s = 8'b01000101;
      5'd17:   s = 8'b01000110;
      5'd18:   s = 8'b01010000;
      5'd19:   s = 8'b01010001;
      5'd20:   s = 8'b01010010;
      5'd21:   s = 8'b00001000;
      5'd22:   s = 8'b00011000;
      5'd23:   s = 8'b01001000;
      5'd24:   s = 8'b01010100;
      5'd25:   s = 8'b01011000;
      5'd26:   s = 8'b00100000;
      5'd27:   s = 8'b01100000;
      5'd28:   s = 8'b10000000;
      default: s = 8'b00000000;
    endcase
    return s;
  endfunction

  // First requester at or after ptr, wrapping past 28 back to 0.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int off = 0; off < N; off++) begin
      cand = (IDX_W+1)'(ptr) + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!pick_found && req[cand[IDX_W-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign release_c = done || !req[grant_idx] || (cnt == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= '0;
      cnt         <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_idx   <= '0;
      sel         <= '0;
      timeout     <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state       <= BUSY;
            cnt         <= '0;
            grant       <= N'(1) << pick_idx;
            grant_valid <= 1'b1;
            grant_idx   <= pick_idx;
            sel         <= sel_of(pick_idx);
          end
        end
        BUSY: begin
          if (release_c) begin
            // Returning through IDLE gives the mux one settle cycle at sel=0.
            state       <= IDLE;
            cnt         <= '0;
            grant       <= '0;
            grant_valid <= 1'b0;
            grant_idx   <= '0;
            sel         <= '0;
            ptr         <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
            timeout     <= !done && req[grant_idx];
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux29_rr_sched.sv
// Scoreboarded bench for mux29_rr_sched: a tenure/round-robin reference model
// predicts every cycle's outputs, and a separate monitor compares them.
`timescale 1ns/1ps
module tb_mux29_rr_sched;

  localparam int unsigned HOLD_MAX = 16;
  localparam int unsigned NREQ     = 29;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [28:0] req;
  logic        done;
  logic [28:0] grant;
  logic        grant_valid;
  logic [4:0]  grant_idx;
  logic [7:0]  sel;
  logic        timeout;

  logic [28:0] inp = 29'b11100011100011100011100011100;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [28:0] g;
    logic        v;
    logic [4:0]  i;
    logic [7:0]  s;
    logic        t;
  } exp_t;

  exp_t exp_q[$];
  int   glog[$];

  logic [7:0] tbl [29] = '{
    8'b00000000, 8'b00000001, 8'b00000010, 8'b00000100, 8'b00000101, 8'b00000110,
    8'b00010000, 8'b00010001, 8'b00010010, 8'b00010100, 8'b00010101, 8'b00010110,
    8'b01000000, 8'b01000001, 8'b01000010, 8'b01000100, 8'b01000101, 8'b01000110,
    8'b01010000, 8'b01010001, 8'b01010010,
    8'b00001000, 8'b00011000, 8'b01001000, 8'b01010100, 8'b01011000,
    8'b00100000, 8'b01100000, 8'b10000000};

  mux29_rr_sched #(.HOLD_MAX(HOLD_MAX), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .sel(sel), .timeout(timeout));

  always #5 clk = ~clk;

  // Behavioural 29:1 mux driven by the select code.
  function automatic logic mux_out(input logic [7:0] s);
    for (int i = 0; i < 29; i++)
      if (tbl[i] == s) return inp[i];
    return 1'b0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference model: who holds the mux, for how many cycles so far, and where the search resumes.
  bit m_busy = 0;
  int m_idx  = 0;
  int m_held = 0;
  int m_ptr  = 0;

  always @(posedge clk) begin
    exp_t e;
    bit   tmo;
    tmo = 0;
    if (!rst_n) begin
      m_busy = 0; m_idx = 0; m_held = 0; m_ptr = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!m_busy && req[j]) begin
          m_busy = 1; m_idx = j; m_held = 1;
        end
      end
    end else begin
      if (done || !req[m_idx] || m_held == HOLD_MAX) begin
        tmo    = !done && req[m_idx];
        m_busy = 0;
        m_ptr  = (m_idx + 1) % NREQ;
      end else begin
        m_held++;
      end
    end
    e.v = m_busy;
    e.g = m_busy ? (29'd1 << m_idx) : 29'd0;
    e.i = m_busy ? 5'(m_idx) : 5'd0;
    e.s = m_busy ? tbl[m_idx] : 8'd0;
    e.t = tmo;
    exp_q.push_back(e);
  end

  // Monitor: compare every cycle's registered outputs against the model.
  logic prev_v = 1'b0;
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("grant_valid", 32'(grant_valid), 32'(e.v));
      chk("grant", 32'(grant), 32'(e.g));
      chk("grant_idx", 32'(grant_idx), 32'(e.i));
      chk("sel", 32'(sel), 32'(e.s));
      chk("timeout", 32'(timeout), 32'(e.t));
      if (e.v) chk("outp", 32'(mux_out(sel)), 32'(inp[e.i]));
    end
    if (grant_valid === 1'b1 && prev_v !== 1'b1) glog.push_back(int'(grant_idx));
    prev_v = grant_valid;
  end

  task automatic wait_grant();
    int n = 0;
    while (grant_valid !== 1'b1 && n < 60) begin
      @(negedge clk); n++;
    end
    if (grant_valid !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_grant: got no grant expected grant_valid=1 at %0t", $time);
    end
  endtask

  task automatic done_now();
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_log(input string name, input int pos, input int expv);
    if (glog.size() > pos) chk(name, 32'(glog[pos]), 32'(expv));
    else chk(name, 32'hdead, 32'(expv));
  endtask

  initial begin
    rst_n = 1'b0; req = '1; done = 1'b0;
    idle_cycles(2);
    req = 29'd1; rst_n = 1'b1;
    wait_grant();
    req = '0;
    idle_cycles(3);

    // Round robin over 3, 19, 28.
    glog.delete();
    req = (29'd1 << 3) | (29'd1 << 19) | (29'd1 << 28);
    for (int r = 0; r < 4; r++) begin
      wait_grant();
      done_now();
    end
    req = '0;
    idle_cycles(3);
    chk_log("rr0", 0, 3); chk_log("rr1", 1, 19); chk_log("rr2", 2, 28); chk_log("rr3", 3, 3);

    // Request drop, then wrap from 28 to 5.
    glog.delete();
    req = 29'd1 << 27;
    wait_grant();
    idle_cycles(3);
    req = (29'd1 << 5) | (29'd1 << 28);
    idle_cycles(1);
    wait_grant(); done_now();
    wait_grant(); done_now();
    req = '0;
    idle_cycles(3);
    chk_log("drop0", 0, 27); chk_log("drop1", 1, 28); chk_log("drop2", 2, 5);

    // Tenure limit with a single persistent requester.
    glog.delete();
    req = 29'd1 << 24;
    idle_cycles(3 * (HOLD_MAX + 1) + 2);
    req = '0;
    idle_cycles(3);
    chk_log("tmo0", 0, 24); chk_log("tmo1", 1, 24); chk_log("tmo2", 2, 24);

    // Grant sweep across every index; monitor checks the mux output.
    for (int k = 0; k < NREQ; k++) begin
      req = 29'd1 << k;
      wait_grant();
      done_now();
      req = '0;
      idle_cycles(1);
    end

    // Reset mid-grant, then the pointer restarts at 0.
    glog.delete();
    req = 29'd1 << 12;
    wait_grant();
    idle_cycles(2);
    rst_n = 1'b0; req = (29'd1 << 12) | 29'd1;
    idle_cycles(1);
    rst_n = 1'b1;
    wait_grant(); done_now();
    req = '0;
    idle_cycles(3);
    chk_log("rst0", 0, 12); chk_log("rst1", 1, 0);

    // Random traffic.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 7) == 0) req = 29'($urandom) & 29'($urandom);
      done  = ($urandom_range(0, 5) == 0);
      rst_n = ($urandom_range(0, 149) != 0);
      @(negedge clk);
    end
    rst_n = 1'b1; done = 1'b0; req = '0;
    idle_cycles(4);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
